// File: rtl/pe_pkg.sv
// Shared definitions for the systolic PE array: feeder state encoding,
// default element width and the element slice helper used by array, feeder and collector.
package pe_pkg;

  localparam int PE_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } pe_state_e;

  // LSB of row r's element inside a packed ROWS*width vector.
  function automatic int elem_lsb(input int row, input int width);
    return row * width;
  endfunction

endpackage

// File: rtl/pe_vec_fifo.sv
// Circular vector buffer for the row feeder; pointers carry one extra wrap bit
// so full and empty are distinguished and fill level is a plain subtraction.
module pe_vec_fifo
  import pe_pkg::*;
#(
  parameter int WIDTH = 4 * PE_DATA_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                     PE_clk,
  input  logic                     PE_rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr = i_wr && !o_full;
  assign w_do_rd = i_rd && !o_empty;

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset: contents are only observable through valid pointers.
  always_ff @(posedge PE_clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_fill  = r_wptr - r_rptr;
  assign o_full  = (o_fill == (AW+1)'(DEPTH));
  assign o_empty = (r_wptr == r_rptr);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/pe_row_feeder.sv
// Buffers activation vectors and streams them into the PE array's left edge,
// skewing row r by r cycles so operands meet the column partial sums on time.
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = PE_DATA_WIDTH,
  parameter int ROWS       = 4,
  parameter int DEPTH      = 8
) (
  input  logic                         PE_clk,
  input  logic                         PE_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic [ROWS-1:0]              feed_en,
  output logic [ROWS*DATA_WIDTH-1:0]   feed_data
);

  localparam int VW = ROWS * DATA_WIDTH;
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Handshake: a vector is taken on a rising edge where in_valid && in_ready;
  // in_ready is only offered in IDLE with space left, in_valid is ignored otherwise.

  pe_state_e       r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_done;
  logic            r_busy;
  logic            r_rdy_en;

  logic            w_wr;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [VW-1:0]   w_head;
  logic [FW-1:0]   w_fill;

  assign in_ready   = r_rdy_en && (r_state == ST_IDLE) && !w_full;
  assign w_wr       = in_valid && in_ready;
  assign w_pop      = (r_state == ST_STREAM) && !w_empty;
  assign busy       = r_busy;
  assign done       = r_done;
  assign fill_level = w_fill;

  pe_vec_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .PE_clk   (PE_clk),
    .PE_rst_n (PE_rst_n),
    .i_wr     (w_wr),
    .i_wdata  (in_data),
    .i_rd     (w_pop),
    .o_rdata  (w_head),
    .o_fill   (w_fill),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_rdy_en    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A write landing on the start edge belongs to the batch.
          if (start) begin
            if ((w_fill != '0) || w_wr) begin
              r_state <= ST_STREAM;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (w_fill <= FW'(1)) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= CW'(ROWS - 1);
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Row r: stage 0 captures the popped element, then r more stages of delay.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    logic [gr:0]           r_v;
    logic [DATA_WIDTH-1:0] r_d [0:gr];

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
      if (!PE_rst_n) begin
        r_v <= '0;
        for (int j = 0; j <= gr; j++) r_d[j] <= '0;
      end else begin
        r_v[0] <= w_pop;
        if (w_pop) r_d[0] <= w_head[elem_lsb(gr, DATA_WIDTH) +: DATA_WIDTH];
        // Data only advances behind a valid so the output holds its last element.
        for (int j = 1; j <= gr; j++) begin
          r_v[j] <= r_v[j-1];
          if (r_v[j-1]) r_d[j] <= r_d[j-1];
        end
      end
    end

    assign feed_en[gr]                                   = r_v[gr];
    assign feed_data[gr*DATA_WIDTH +: DATA_WIDTH]        = r_d[gr];
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder: expected per-row elements with their cycle
// of arrival and expected done cycles are queued at start; a monitor consumes them.
module tb_pe_row_feeder;

  localparam int DW    = 32;
  localparam int ROWS  = 4;
  localparam int DEPTH = 8;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [FW-1:0]        fill_level;
  logic [ROWS-1:0]      feed_en;
  logic [ROWS*DW-1:0]   feed_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int next_k = 0;

  logic [63:0]        exp_q [ROWS][$];
  int                 done_q[$];
  logic [ROWS*DW-1:0] model_q[$];

  pe_row_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .PE_clk     (clk),
    .PE_rst_n   (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .fill_level (fill_level),
    .feed_en    (feed_en),
    .feed_data  (feed_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: cyc=%0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] vec(input int k);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 32'(16 * k + r);
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic write_vecs(input int n);
    for (int i = 0; i < n; i++) begin
      chk("wr_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = vec(next_k);
      model_q.push_back(in_data);
      next_k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Start edge t is the next posedge; row r sees vector k at cyc t+1+r+k.
  task automatic do_start();
    int t;
    int n;
    logic [ROWS*DW-1:0] v;
    t = cyc + 1;
    n = model_q.size();
    start = 1'b1;
    if (n == 0) begin
      done_q.push_back(t);
    end else begin
      for (int k = 0; k < n; k++) begin
        v = model_q.pop_front();
        for (int r = 0; r < ROWS; r++)
          exp_q[r].push_back({32'(t + 1 + r + k), v[r*DW +: DW]});
      end
      done_q.push_back(t + n + ROWS);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    while (busy && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic int pending();
    int s;
    s = done_q.size();
    for (int r = 0; r < ROWS; r++) s += exp_q[r].size();
    return s;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        if (feed_en[r]) begin
          if (exp_q[r].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed_unexpected row %0d: got data %0h at cyc %0d, none required", r, feed_data[r*DW +: DW], cyc);
          end else begin
            e = exp_q[r].pop_front();
            chk($sformatf("feed_row%0d", r), {32'(cyc), feed_data[r*DW +: DW]}, e);
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL done_unexpected: got done at cyc %0d, none required", cyc);
        end else begin
          chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = '0;

    // Reset with random input activity
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      start    = 1'($urandom_range(0, 1));
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    @(negedge clk);
    chk("rst_feed_en", 64'(feed_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic batch of 3: row 2 carries 2, 18, 34
    write_vecs(3);
    chk("basic_fill", 64'(fill_level), 64'd3);
    do_start();
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("basic_fill_pop1", 64'(fill_level), 64'd2);
    wait_idle(40);
    chk("basic_in_ready_back", 64'(in_ready), 64'd1);
    chk("basic_pending", 64'(pending()), 64'd0);

    // Full buffer, extra write refused
    write_vecs(DEPTH);
    chk("full_fill", 64'(fill_level), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = vec(99);
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_fill_hold", 64'(fill_level), 64'(DEPTH));
    do_start();
    wait_idle(60);
    chk("full_pending", 64'(pending()), 64'd0);
    chk("full_fill_after", 64'(fill_level), 64'd0);

    // Empty start: done next cycle, never busy
    chk("empty_fill", 64'(fill_level), 64'd0);
    do_start();
    chk("empty_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("empty_pending", 64'(pending()), 64'd0);

    // start and in_valid during STREAM are ignored
    write_vecs(4);
    do_start();
    in_valid = 1'b1;
    start    = 1'b1;
    in_data  = vec(77);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    chk("ign_fill", 64'(fill_level), 64'd2);
    chk("ign_busy", 64'(busy), 64'd1);
    wait_idle(40);
    repeat (4) @(negedge clk);
    chk("ign_pending", 64'(pending()), 64'd0);

    // Reset while draining
    write_vecs(2);
    do_start();
    b = 0;
    while ((fill_level != 0) && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("mid_reach_drain", 64'(fill_level), 64'd0);
    chk("mid_busy_drain", 64'(busy), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_feed_en_async", 64'(feed_en), 64'd0);
    chk("mid_busy_async", 64'(busy), 64'd0);
    for (int r = 0; r < ROWS; r++) exp_q[r].delete();
    done_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_fill_after", 64'(fill_level), 64'd0);
    chk("mid_in_ready_after", 64'(in_ready), 64'd1);
    chk("mid_done_low", 64'(done), 64'd0);

    chk("final_pending", 64'(pending()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
